// File: rtl/seq_div_32_if.sv
// seq_div_32 handshake bundle: start/operands in, status/results out.
// Control unit is master, divider is slave.
interface seq_div_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_div_32.sv
// seq_div_32: multi-cycle restoring divider, quotient -> ZLow, remainder -> ZHigh.
// Define SEQ_DIV_SIGNED_EN for two's-complement signed division (default unsigned).
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         clear,
    seq_div_32_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic             zero_div;
    logic             busy_d;
    logic             done_d;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef SEQ_DIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic [WIDTH-1:0] r_src;

    always_comb begin
        a_mag = bus.dividend[WIDTH-1] ? WIDTH'(0) - bus.dividend : bus.dividend;
        b_mag = bus.divisor[WIDTH-1]  ? WIDTH'(0) - bus.divisor  : bus.divisor;
        // remainder follows the dividend's sign: truncation toward zero
        r_src = zero_div ? quo : acc;
        r_fix = sign_a ? WIDTH'(0) - r_src : r_src;
        q_fix = (sign_a ^ sign_b) ? WIDTH'(0) - quo : quo;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            sign_a <= bus.dividend[WIDTH-1];
            sign_b <= bus.divisor[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        r_fix = zero_div ? quo : acc;
        q_fix = quo;
    end
`endif

    // one restoring step: WIDTH+1-bit trial subtract, top bit is the borrow
    always_comb begin
        shifted = {acc, quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dsr};
    end

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start)
                      state_nx = (bus.divisor == '0) ? FIX : CALC;
            CALC: if (count == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state == CALC) || (state == FIX);
        done_d = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            count    <= '0;
            acc      <= '0;
            quo      <= '0;
            dsr      <= '0;
            zero_div <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            case (state)
                IDLE: if (bus.start) begin
                    quo      <= a_mag;
                    dsr      <= b_mag;
                    acc      <= '0;
                    count    <= CW'(WIDTH);
                    zero_div <= (bus.divisor == '0);
                    dbz_q    <= 1'b0;
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (!diff[WIDTH+1]) begin
                        acc <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    quot_q <= zero_div ? '1 : q_fix;
                    rem_q  <= r_fix;
                    dbz_q  <= zero_div;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
endmodule

// File: tb/tb_seq_div_32.sv
// Directed bench for seq_div_32: reset, latency, results, div-by-zero, protocol.
// Signed vectors are used when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div_32;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_div_32_if #(.WIDTH(32)) bus ();

    seq_div_32 #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // start at edge N; lat = edges after N until done, bcnt = busy samples
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        @(negedge clock);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = b ^ 32'h5;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] q,
                       input logic [31:0] r, input int lat_exp);
        int lat, bcnt;
        do_div(a, b, lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, bus.remainder, r);
    endtask

    initial begin
        int lat, bcnt, seen;
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", bus.quotient, 32'd0);
        chk("rst_r", bus.remainder, 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        bus.start = 1'b0;
        @(negedge clock);
        clear = 1'b0;

        do_div(32'd100, 32'd7, lat, bcnt);
        chk("basic_lat", 32'(lat), 32'd34);
        chk("basic_busy", 32'(bcnt), 32'd33);
        chk("basic_q", bus.quotient, 32'd14);
        chk("basic_r", bus.remainder, 32'd2);
        chk("basic_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clock);
        #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("hold_q", bus.quotient, 32'd14);

        vec("small", 32'd7, 32'd100, 32'd0, 32'd7, 34);
        vec("exact", 32'd144, 32'd12, 32'd12, 32'd0, 34);
`ifdef SEQ_DIV_SIGNED_EN
        vec("neg_a", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);
        vec("neg_b", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 34);
        vec("neg_ab", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 34);
        vec("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        chk("ovf_dbz", 32'(bus.div_by_zero), 32'd0);
        vec("dz_neg", 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 2);
`else
        vec("umax2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 34);
        vec("umsb", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 34);
        vec("ubig_b", 32'd100, 32'hFFFF_FFF9, 32'd0, 32'd100, 34);
        vec("umaxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 34);
`endif

        vec("dz", 32'h0000_0064, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064, 2);
        chk("dz_flag", 32'(bus.div_by_zero), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        chk("dz_hold", 32'(bus.div_by_zero), 32'd1);
        vec("after_dz", 32'd9, 32'd3, 32'd3, 32'd0, 34);
        chk("dz_clr", 32'(bus.div_by_zero), 32'd0);

        // second start mid-operation must be ignored
        @(negedge clock);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.dividend = 32'd50;
        bus.divisor  = 32'd1;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("ign_lat", 32'(lat), 32'd34);
        chk("ign_q", bus.quotient, 32'd14);
        chk("ign_r", bus.remainder, 32'd2);

        // reset mid-operation abandons it
        @(negedge clock);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_q", bus.quotient, 32'd0);
        chk("mrst_r", bus.remainder, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) seen++;
        end
        chk("mrst_nodone", 32'(seen), 32'd0);
        vec("fresh", 32'd1000, 32'd33, 32'd30, 32'd10, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_div_32.md
Name: seq_div_32

Overview:
- Multi-cycle 32-bit integer divider for the datapath ALU's DIV operation.
- Takes its dividend from the Y register and its divisor from the bus.
- Produces quotient for ZLow and remainder for ZHigh, latched into the Z register pair on done.
- Sits beside the combinational logic units (NOT/AND/OR/shift); it is the one ALU unit needing a sequencer handshake with the control unit.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  reset, synchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- dividend  input  WIDTH  numerator (Y register)
- divisor  input  WIDTH  denominator (bus)
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; quotient/remainder valid
- div_by_zero  output  1  set with done when divisor == 0; held until next accepted start
- quotient  output  WIDTH  result to ZLow
- remainder  output  WIDTH  result to ZHigh

Behaviour:
- Reset: clear=1 at a clock edge forces state=IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, internal counter=0.
- Mid-operation reset: clear overrides everything, including start on the same edge. The operation is abandoned and done never fires.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 captures |dividend| and |divisor| plus both sign bits, loads counter=WIDTH, clears the partial remainder, then goes to CALC (or straight to FIX if divisor==0).
  - div_by_zero is cleared on any accepted start.
- CALC: one restoring step per cycle.
  - Shift {partial remainder, dividend magnitude} left by 1 and trial-subtract the divisor magnitude.
  - If no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; at counter==1 the step completes and the state goes to FIX.
  - Arithmetic is WIDTH+1 bits wide, so the magnitude 2^31 is valid.
- FIX:
  - Quotient is negated if the operand signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - Results are written to the output registers, then the state goes to DONE.
  - Divide by zero: quotient = all ones, remainder = dividend unchanged, div_by_zero=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. Outputs hold until the next accepted start completes FIX.
- Latency:
  - start sampled at edge N gives done high in the cycle after edge N+WIDTH+2 (34 edges for WIDTH=32).
  - Divide by zero gives done after edge N+2.
- busy is 1 in CALC and FIX, 0 in IDLE and DONE. start while not IDLE (including DONE) is ignored, with no queuing.
- Overflow case: -2^31 / -1 yields quotient 0x8000_0000 (wraps), remainder 0, div_by_zero=0.
- Inputs are sampled only at start. Later changes to dividend or divisor have no effect.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: two's-complement signed division as described above.
- Undefined: operands are treated as unsigned. Sign capture and negation are removed, and FIX still occupies one cycle (latency unchanged) but only registers results.
- Divide-by-zero behaviour is identical in both builds.

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Basic division: dividend=100, divisor=7, start pulse -> done after 34 edges; quotient=14, remainder=2, busy high for exactly 33 cycles.
- Signed (macro on): -100/7 -> quotient=-14 (0xFFFF_FFF2), remainder=-2. 100/-7 -> quotient=-14, remainder=2. -2^31/-1 -> quotient=0x8000_0000, remainder=0.
- Signed build (macro on): dividend=0x0000_0064, divisor=0 -> done after 2 edges, div_by_zero=1, quotient=0xFFFF_FFFF, remainder=0x64. A following 9/3 clears div_by_zero and gives quotient 3.
- Unsigned build (macro off): 0xFFFF_FFFF/2 -> quotient=0x7FFF_FFFF, remainder=1.
- Protocol (macro on): start pulsed again at cycle 10 with new operands -> ignored, original 100/7 result returned. Reset pulsed at cycle 20 -> no done, outputs 0; a fresh start then completes normally.
